// File: rtl/scroll_feeder_if.sv
`timescale 1ns/1ps
// Value handshake, pause control and digit-write / scroll outputs of scroll_feeder.
interface scroll_feeder_if;
  logic        i_valid;
  logic [11:0] i_data;
  logic        i_pause;
  logic        o_ready;
  logic [3:0]  o_dec;
  logic        o_wr_en;
  logic [1:0]  o_wr_idx;
  logic        o_start;
  logic [2:0]  o_step;
  logic        o_busy;
  logic        o_done;

  modport slave (
    input  i_valid, i_data, i_pause,
    output o_ready, o_dec, o_wr_en, o_wr_idx, o_start, o_step, o_busy, o_done
  );

  modport master (
    output i_valid, i_data, i_pause,
    input  o_ready, o_dec, o_wr_en, o_wr_idx, o_start, o_step, o_busy, o_done
  );
endinterface

// File: rtl/scroll_feeder.sv
`timescale 1ns/1ps
// Accepts a three-digit BCD word, writes its digits one per cycle, then steps the
// scroller through seven window positions at STEP_CYCLES cycles per position.
module scroll_feeder #(
  parameter int unsigned STEP_CYCLES = 4
) (
  input logic            clk,
  input logic            rst,
  scroll_feeder_if.slave bus
);
  localparam int unsigned     TIMER_W    = 8;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STEP_CYCLES - 1);
  localparam logic [2:0]      LAST_STEP  = 3'd6;
  localparam logic [1:0]      LAST_SLOT  = 2'd2;
  localparam logic [3:0]      BLANK      = 4'hF;

  typedef enum logic [1:0] {IDLE, LOAD, SCROLL, DONE} state_t;

  state_t             state;
  logic [11:0]        hold;
  logic [1:0]         cnt;
  logic [TIMER_W-1:0] timer;
  logic [2:0]         step;

  // Slot 0 is the most significant digit; non-BCD nibbles display as blank.
  function automatic logic [3:0] slot_digit(input logic [11:0] w, input logic [1:0] idx);
    logic [3:0] n;
    case (idx)
      2'd0:    n = w[11:8];
      2'd1:    n = w[7:4];
      default: n = w[3:0];
    endcase
    return (n > 4'd9) ? BLANK : n;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hold         <= '0;
      cnt          <= '0;
      timer        <= '0;
      step         <= '0;
      bus.o_ready  <= 1'b1;
      bus.o_dec    <= BLANK;
      bus.o_wr_en  <= 1'b0;
      bus.o_wr_idx <= '0;
      bus.o_start  <= 1'b0;
      bus.o_step   <= '0;
      bus.o_busy   <= 1'b0;
      bus.o_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid && bus.o_ready) begin
            state        <= LOAD;
            hold         <= bus.i_data;
            cnt          <= '0;
            bus.o_ready  <= 1'b0;
            bus.o_busy   <= 1'b1;
            bus.o_wr_en  <= 1'b1;
            bus.o_wr_idx <= '0;
            bus.o_dec    <= slot_digit(bus.i_data, 2'd0);
          end
        end

        LOAD: begin
          if (cnt == LAST_SLOT) begin
            state        <= SCROLL;
            cnt          <= '0;
            timer        <= '0;
            step         <= '0;
            bus.o_wr_en  <= 1'b0;
            bus.o_wr_idx <= '0;
            bus.o_dec    <= BLANK;
            bus.o_start  <= 1'b1;
            bus.o_step   <= '0;
          end else begin
            cnt          <= cnt + 2'd1;
            bus.o_wr_idx <= cnt + 2'd1;
            bus.o_dec    <= slot_digit(hold, cnt + 2'd1);
          end
        end

        SCROLL: begin
          // A paused cycle freezes the timer, stretching the current step by one cycle.
          if (!bus.i_pause) begin
            if (timer == TIMER_LAST) begin
              timer <= '0;
              if (step == LAST_STEP) begin
                state       <= DONE;
                step        <= '0;
                bus.o_start <= 1'b0;
                bus.o_step  <= '0;
                bus.o_done  <= 1'b1;
              end else begin
                step       <= step + 3'd1;
                bus.o_step <= step + 3'd1;
              end
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
        end

        DONE: begin
          state       <= IDLE;
          bus.o_done  <= 1'b0;
          bus.o_busy  <= 1'b0;
          bus.o_ready <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scroll_feeder.sv
`timescale 1ns/1ps
// Scoreboard bench for scroll_feeder: one DUT at STEP_CYCLES=4 and one at STEP_CYCLES=1.
module tb_scroll_feeder;
  logic clk = 1'b0;
  logic rst;
  logic rst1;
  int   tests_run = 0;
  int   tests_failed = 0;

  scroll_feeder_if bus4();
  scroll_feeder_if bus1();

  scroll_feeder #(.STEP_CYCLES(4)) dut  (.clk(clk), .rst(rst),  .bus(bus4));
  scroll_feeder #(.STEP_CYCLES(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  always #5 clk = ~clk;

  localparam int MAXC = 64;
  logic [11:0] din     [MAXC];
  logic [3:0]  t_dec   [MAXC];
  logic        t_wr    [MAXC];
  logic [1:0]  t_idx   [MAXC];
  logic        t_start [MAXC];
  logic [2:0]  t_step  [MAXC];
  logic        t_busy  [MAXC];
  logic        t_done  [MAXC];
  logic        t_ready [MAXC];
  logic [3:0]  q_dec[$];

  function automatic logic [3:0] san(input logic [3:0] n);
    return (n > 4'd9) ? 4'hF : n;
  endfunction

  // Expected {wr_en, wr_idx, dec, start, step, busy, done, ready} in cycle k after a handshake at cycle 0.
  function automatic logic [13:0] exp_vec(input int k, input int s, input logic [3:0] dq);
    logic       wr;
    logic       st;
    logic [1:0] idx;
    logic [2:0] stp;
    wr  = (k >= 1 && k <= 3);
    idx = wr ? 2'(k - 1) : 2'd0;
    st  = (k >= 4 && k < 4 + 7 * s);
    stp = st ? 3'((k - 4) / s) : 3'd0;
    return {wr, idx, (wr ? dq : 4'hF), st, stp, (k >= 1 && k <= 4 + 7 * s),
            (k == 4 + 7 * s), (k == 0 || k >= 5 + 7 * s)};
  endfunction

  function automatic logic [13:0] obs_vec(input int k);
    return {t_wr[k], t_idx[k], t_dec[k], t_start[k], t_step[k], t_busy[k], t_done[k], t_ready[k]};
  endfunction

  // Drives cycles 0..n-1 starting from IDLE (valid forced in cycle 0) and records outputs.
  task automatic capture(input bit sel1, input int n, input bit hold_valid, input int p_lo, input int p_hi);
    for (int k = 0; k < n; k++) begin
      if (sel1) begin
        bus1.i_valid = (k == 0) || hold_valid;
        bus1.i_data  = din[k];
        bus1.i_pause = (k >= p_lo && k <= p_hi);
        t_dec[k] = bus1.o_dec;   t_wr[k]   = bus1.o_wr_en; t_idx[k]  = bus1.o_wr_idx;
        t_start[k] = bus1.o_start; t_step[k] = bus1.o_step; t_busy[k] = bus1.o_busy;
        t_done[k] = bus1.o_done; t_ready[k] = bus1.o_ready;
      end else begin
        bus4.i_valid = (k == 0) || hold_valid;
        bus4.i_data  = din[k];
        bus4.i_pause = (k >= p_lo && k <= p_hi);
        t_dec[k] = bus4.o_dec;   t_wr[k]   = bus4.o_wr_en; t_idx[k]  = bus4.o_wr_idx;
        t_start[k] = bus4.o_start; t_step[k] = bus4.o_step; t_busy[k] = bus4.o_busy;
        t_done[k] = bus4.o_done; t_ready[k] = bus4.o_ready;
      end
      @(posedge clk); #1;
    end
    bus4.i_valid = 1'b0; bus4.i_pause = 1'b0;
    bus1.i_valid = 1'b0; bus1.i_pause = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] rv;
    rv = {1'b0, 2'd0, 4'hF, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
    rst = 1'b1; rst1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({bus4.o_wr_en, bus4.o_wr_idx, bus4.o_dec, bus4.o_start, bus4.o_step, bus4.o_busy,
         bus4.o_done, bus4.o_ready} !== rv) begin
      tests_failed++;
      $display("FAIL reset_s4: got %h expected %h", {bus4.o_wr_en, bus4.o_wr_idx, bus4.o_dec,
               bus4.o_start, bus4.o_step, bus4.o_busy, bus4.o_done, bus4.o_ready}, rv);
    end
    tests_run++;
    if ({bus1.o_wr_en, bus1.o_wr_idx, bus1.o_dec, bus1.o_start, bus1.o_step, bus1.o_busy,
         bus1.o_done, bus1.o_ready} !== rv) begin
      tests_failed++;
      $display("FAIL reset_s1: got %h expected %h", {bus1.o_wr_en, bus1.o_wr_idx, bus1.o_dec,
               bus1.o_start, bus1.o_step, bus1.o_busy, bus1.o_done, bus1.o_ready}, rv);
    end
    rst = 1'b0; rst1 = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (bus4.o_ready !== 1'b1 || bus4.o_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: ready=%b busy=%b expected ready=1 busy=0", bus4.o_ready, bus4.o_busy);
    end
  endtask

  task automatic test_basic();
    logic [3:0] dq;
    for (int k = 0; k < MAXC; k++) din[k] = 12'h123;
    q_dec.push_back(4'h1); q_dec.push_back(4'h2); q_dec.push_back(4'h3);
    capture(1'b0, 34, 1'b0, 1000, 0);
    for (int k = 0; k < 34; k++) begin
      dq = 4'hF;
      if (k >= 1 && k <= 3) dq = q_dec.pop_front();
      tests_run++;
      if (obs_vec(k) !== exp_vec(k, 4, dq)) begin
        tests_failed++;
        $display("FAIL basic cycle %0d: got %h expected %h", k, obs_vec(k), exp_vec(k, 4, dq));
      end
    end
  endtask

  task automatic test_sanitize();
    logic [3:0] dq;
    for (int k = 0; k < MAXC; k++) din[k] = 12'hA5F;
    q_dec.push_back(4'hF); q_dec.push_back(4'h5); q_dec.push_back(4'hF);
    capture(1'b0, 34, 1'b0, 1000, 0);
    for (int k = 0; k < 34; k++) begin
      dq = 4'hF;
      if (k >= 1 && k <= 3) dq = q_dec.pop_front();
      tests_run++;
      if (obs_vec(k) !== exp_vec(k, 4, dq)) begin
        tests_failed++;
        $display("FAIL sanitize cycle %0d: got %h expected %h", k, obs_vec(k), exp_vec(k, 4, dq));
      end
    end
  endtask

  task automatic test_pause();
    int   step3_len;
    int   done_at;
    int   done_cnt;
    logic [3:0] dq;
    for (int k = 0; k < MAXC; k++) din[k] = 12'h246;
    q_dec.push_back(4'h2); q_dec.push_back(4'h4); q_dec.push_back(4'h6);
    capture(1'b0, 40, 1'b0, 17, 21);
    step3_len = 0; done_at = -1; done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (t_start[k] === 1'b1 && t_step[k] === 3'd3) step3_len++;
      if (t_done[k] === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k >= 1 && k <= 3) begin
        dq = q_dec.pop_front();
        tests_run++;
        if (t_dec[k] !== dq) begin
          tests_failed++;
          $display("FAIL pause_load cycle %0d: dec=%h expected %h", k, t_dec[k], dq);
        end
      end
    end
    tests_run++;
    if (step3_len != 9) begin
      tests_failed++;
      $display("FAIL pause_step3_len: got %0d expected 9", step3_len);
    end
    tests_run++;
    if (done_at != 37 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL pause_done: at cycle %0d count %0d expected cycle 37 count 1", done_at, done_cnt);
    end
    tests_run++;
    if (t_step[25] !== 3'd4 || t_ready[38] !== 1'b1) begin
      tests_failed++;
      $display("FAIL pause_tail: step25=%0d ready38=%b expected 4 and 1", t_step[25], t_ready[38]);
    end
  endtask

  task automatic test_back_to_back();
    bit   exp_wr;
    logic [3:0] dq;
    for (int k = 0; k < MAXC; k++) din[k] = 12'($urandom);
    din[0]  = 12'h159;
    din[33] = 12'h8C0;
    q_dec.push_back(san(din[0][11:8]));  q_dec.push_back(san(din[0][7:4]));  q_dec.push_back(san(din[0][3:0]));
    q_dec.push_back(san(din[33][11:8])); q_dec.push_back(san(din[33][7:4])); q_dec.push_back(san(din[33][3:0]));
    capture(1'b0, 38, 1'b1, 1000, 0);
    for (int k = 0; k < 38; k++) begin
      exp_wr = (k >= 1 && k <= 3) || (k >= 34 && k <= 36);
      tests_run++;
      if (t_wr[k] !== exp_wr || t_ready[k] !== (k == 0 || k == 33) || t_done[k] !== (k == 32)) begin
        tests_failed++;
        $display("FAIL b2b_ctrl cycle %0d: wr=%b ready=%b done=%b expected %b %b %b", k,
                 t_wr[k], t_ready[k], t_done[k], exp_wr, (k == 0 || k == 33), (k == 32));
      end
      if (exp_wr) begin
        dq = q_dec.pop_front();
        tests_run++;
        if (t_dec[k] !== dq) begin
          tests_failed++;
          $display("FAIL b2b_dec cycle %0d: got %h expected %h", k, t_dec[k], dq);
        end
      end
    end
    for (int c = 0; c < 60 && bus4.o_ready !== 1'b1; c++) begin
      @(posedge clk); #1;
    end
    tests_run++;
    if (bus4.o_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_drain: ready=%b expected 1 within 60 cycles", bus4.o_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] rv;
    int done_cnt;
    int not_ready;
    rv = {1'b0, 2'd0, 4'hF, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < MAXC; k++) din[k] = 12'h456;
    capture(1'b0, 14, 1'b0, 1000, 0);
    tests_run++;
    if (t_step[13] !== 3'd2 || t_start[13] !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_pre: step=%0d start=%b expected 2 and 1", t_step[13], t_start[13]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if ({bus4.o_wr_en, bus4.o_wr_idx, bus4.o_dec, bus4.o_start, bus4.o_step, bus4.o_busy,
         bus4.o_done, bus4.o_ready} !== rv) begin
      tests_failed++;
      $display("FAIL rstmid_values: got %h expected %h", {bus4.o_wr_en, bus4.o_wr_idx, bus4.o_dec,
               bus4.o_start, bus4.o_step, bus4.o_busy, bus4.o_done, bus4.o_ready}, rv);
    end
    done_cnt = 0; not_ready = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus4.o_done !== 1'b0) done_cnt++;
      if (bus4.o_ready !== 1'b1) not_ready++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (done_cnt != 0 || not_ready != 0) begin
      tests_failed++;
      $display("FAIL rstmid_quiet: done cycles %0d not-ready cycles %0d expected 0 and 0", done_cnt, not_ready);
    end
  endtask

  task automatic test_step1();
    logic [3:0] dq;
    for (int k = 0; k < MAXC; k++) din[k] = 12'h987;
    q_dec.push_back(4'h9); q_dec.push_back(4'h8); q_dec.push_back(4'h7);
    capture(1'b1, 13, 1'b0, 1000, 0);
    for (int k = 0; k < 13; k++) begin
      dq = 4'hF;
      if (k >= 1 && k <= 3) dq = q_dec.pop_front();
      tests_run++;
      if (obs_vec(k) !== exp_vec(k, 1, dq)) begin
        tests_failed++;
        $display("FAIL step1 cycle %0d: got %h expected %h", k, obs_vec(k), exp_vec(k, 1, dq));
      end
    end
  endtask

  initial begin
    bus4.i_valid = 1'b0; bus4.i_data = '0; bus4.i_pause = 1'b0;
    bus1.i_valid = 1'b0; bus1.i_data = '0; bus1.i_pause = 1'b0;
    rst = 1'b1; rst1 = 1'b1;
    test_reset();
    test_basic();
    test_sanitize();
    test_pause();
    test_back_to_back();
    test_reset_mid();
    test_step1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/scroll_feeder.md
# scroll_feeder

Transmit-side sequencer for the three-digit scrolling display path. It accepts one 12-bit, three-digit BCD word per transaction over a valid/ready handshake. It writes the three digits one per cycle on the digit-write interface, then drives the scroll-enable and step index through seven window positions at a programmable rate. It sits between the application logic that produces values and the display scroller that consumes `dec`/`wr_en`/`start`.

## Interface
- `STEP_CYCLES`, default 4: clock cycles each scroll step is held; legal range 1..255.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  a value is offered on `i_data`.
- `i_data`  in  12  three BCD digits; `[11:8]` is written first, `[3:0]` last.
- `i_pause`  in  1  freezes the step timer while in SCROLL.
- `o_ready`  out  1  the block can accept a value; high only in IDLE.
- `o_dec`  out  4  digit being written; `4'hF` (blank) when not writing.
- `o_wr_en`  out  1  digit-write strobe; high for exactly 3 cycles per transaction.
- `o_wr_idx`  out  2  slot index of the current write (0, 1, 2).
- `o_start`  out  1  scroll enable; high for the whole SCROLL state.
- `o_step`  out  3  current window position 0..6; 0 outside SCROLL.
- `o_busy`  out  1  high in LOAD, SCROLL and DONE.
- `o_done`  out  1  one-cycle pulse at transaction end.

## Operation
- States:
  - IDLE: `o_ready`=1. On `i_valid`&&`o_ready`, latch `i_data` into a 12-bit holding register and go to LOAD with the write counter at 0.
  - LOAD: `o_wr_en`=1, `o_wr_idx`=counter, `o_dec`=held digit for that slot (counter 0 → `[11:8]`, 1 → `[7:4]`, 2 → `[3:0]`).
    - Counter increments each cycle.
    - After counter 2, go to SCROLL with step=0 and timer=0.
  - SCROLL: `o_start`=1, `o_step`=step.
    - The timer increments each cycle while `i_pause`=0 and holds while `i_pause`=1.
    - When the timer reaches `STEP_CYCLES`-1 and is not paused, the timer returns to 0 and step increments.
    - The increment out of step 6 goes to DONE instead.
  - DONE: `o_done`=1 for one cycle, then IDLE.
- Digit sanitising: any latched nibble greater than 9 is emitted on `o_dec` as `4'hF`. Values 0..9 pass unchanged.
- `i_valid` and `i_data` are ignored outside IDLE. No queuing; the holding register is written only on a handshake.
- `i_pause` has no effect outside SCROLL. A pause asserted on the final timer cycle of step 6 delays DONE.
- Step wrap-around does not exist: the step never exceeds 6, and exactly 7 positions are shown per transaction.
- Timer width is 8 bits. `STEP_CYCLES`=1 advances the step every unpaused cycle.

## Timing
- Reset values (same edge, all outputs registered):
  - state IDLE
  - `o_ready`=1
  - `o_dec`=`4'hF`
  - `o_wr_en`=0, `o_wr_idx`=0
  - `o_start`=0, `o_step`=0
  - `o_busy`=0, `o_done`=0
  - holding register, counter and timer = 0
- Reset during any state aborts the transaction. No `o_done` pulse is produced.
- Handshake at edge 0:
  - Edges 1–3: LOAD (`o_wr_en`=1, `o_wr_idx` 0, 1, 2).
  - Edges 4 to 3+7×`STEP_CYCLES`: SCROLL.
  - Next edge: DONE.
  - Following edge: IDLE with `o_ready`=1.
- Unpaused transaction length is 3 + 7×`STEP_CYCLES` + 1 cycles. At the default `STEP_CYCLES`=4, `o_done` is high in cycle 32 and `o_ready` returns in cycle 33.
- Each paused cycle extends SCROLL by exactly one cycle.
- Back-to-back throughput: a new handshake is possible in the first IDLE cycle after DONE; there is no bubble beyond DONE.
- `o_ready` deasserts in the cycle after a handshake. `i_valid` held high continuously yields one transaction per (length + 1) cycles.

## Test plan
- Reset, then `i_data`=12'h123 with `i_valid` pulsed, `STEP_CYCLES`=4:
  - `o_dec` shows 1, 2, 3 with `o_wr_idx` 0, 1, 2 in cycles 1–3.
  - `o_step` holds each value 0..6 for 4 cycles.
  - `o_done` is high in cycle 32 only.
- `i_data`=12'hA5F: `o_dec` shows F, 5, F during LOAD.
- `i_pause` high for 5 cycles during step 3: step 3 lasts 9 cycles, and `o_done` moves to cycle 37.
- `i_valid` held high with changing `i_data` during busy: only the value present at each IDLE handshake is written; the second transaction starts at cycle 33.
- `rst` asserted during step 2: the next cycle shows all reset values, no `o_done`, and `o_ready`=1.
- `STEP_CYCLES`=1, `i_data`=12'h987: SCROLL lasts exactly 7 cycles with `o_step` 0..6, and `o_done` is in cycle 11.
